cascade_counter: RTL and testbench
==================================

// Module: cascade_counter
// PURPOSE
//  Parametrised multi-stage cascaded up/down counter: STAGES digits of DIGIT_W bits, each counting mod MODULUS.
//  Successor to the single 4-bit enable counter; adds width/modulus generality, direction, load, clear and wrap flagging.
//  Drives clock/stopwatch display datapaths (e.g. 6-digit BCD) and event tallies in lab top levels.
// PARAMETERS
//  STAGES   6   number of cascaded digits (>=1)
//  DIGIT_W  4   bits per digit
//  MODULUS  10  count range per digit, 0..MODULUS-1 (2 <= MODULUS <= 2**DIGIT_W)
// PORTS
//  clk       in   1                 rising-edge clock
//  rst_n     in   1                 asynchronous active-low reset
//  clr       in   1                 synchronous clear to all-zero
//  load      in   1                 synchronous parallel load
//  load_val  in   STAGES*DIGIT_W    load value; digit i at [i*DIGIT_W +: DIGIT_W], digit 0 = LSD
//  en        in   1                 count enable (one step per cycle)
//  up        in   1                 1 = increment, 0 = decrement
//  count     out  STAGES*DIGIT_W    registered count, same packing as load_val
//  tc        out  1                 combinational terminal count: en & (up ? all digits MODULUS-1 : all digits 0)
//  wrap_o    out  1                 registered one-cycle pulse: previous cycle wrapped the full counter
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, wrap_o=0; takes effect immediately, no clk needed; mid-count reset discards state.
//  - Priority per cycle: clr > load > en. clr/load ignore en/up; wrap_o=0 on clr/load cycles.
//  - Load: each digit loaded; any digit value >= MODULUS is loaded as 0 (others unaffected).
//  - Count (en=1): digit 0 steps every cycle; digit i steps when all digits below it are at terminal
//    (MODULUS-1 for up, 0 for down). Up: MODULUS-1 -> 0 carries. Down: 0 -> MODULUS-1 borrows.
//  - Full wrap: up from all-(MODULUS-1) -> all-0, or down from all-0 -> all-(MODULUS-1); wrap_o=1 on the
//    next cycle (registered from tc), exactly one cycle, coincident with the wrapped count value.
//  - en=0: count holds, wrap_o=0. Direction may change any cycle; takes effect that cycle.
//  - Latency: count updates one clock after the control sampled; tc is same-cycle combinational.
//  - Arithmetic: per-digit compare/modular step only; no binary add across digits; no X on any output.
// CONFIGURATION
//  - Macro CASCADE_COUNTER_SATURATE_EN:
//    defined: counter saturates; at all-(MODULUS-1) with up, or all-0 with down, count holds; wrap_o tied 0; tc unchanged.
//    undefined: wrap-around behaviour above (default).
// STRUCTURE
//  - Shared package/header cascade_counter_pkg: localparam CNT_W = STAGES*DIGIT_W, DIGIT_MAX = MODULUS-1,
//    priority encoding of clr/load/en, digit-slice macro.
//  - Sub-module counter_digit (one per stage, generate loop): DIGIT_W-bit mod-MODULUS up/down digit with
//    ci (carry/borrow in), clr, load, load_val, up; outputs q and tc_o (at terminal for current direction & ci).
//  - Top: chains tc_o -> ci of next stage, ANDs stage tc_o for tc, registers wrap_o.
// TESTING (bench with STAGES=2, DIGIT_W=4, MODULUS=10 unless stated)
//  1. rst_n=0 mid-count (count=0x37) between edges -> count=0x00, wrap_o=0 immediately, before next clk.
//  2. load 0x98, en=1 up=1, 3 cycles -> 0x99 (tc=1), 0x00 with wrap_o=1, 0x01 with wrap_o=0.
//  3. load 0x01, en=1 up=0 -> 0x00 (tc=1), then 0x99 with wrap_o=1; 0x10 down -> 0x09 (borrow).
//  4. load 0x5C (digit0=12 illegal) -> count=0x50; clr=1,load=1,en=1 same cycle -> 0x00.
//  5. en toggling 1/0 from 0x00 for 20 cycles -> count=0x10, no wrap_o; up flipped mid-run reverses next cycle.
//  6. Rebuild with CASCADE_COUNTER_SATURATE_EN: at 0x99 up en for 5 cycles -> holds 0x99, wrap_o=0;
//     at 0x00 down -> holds 0x00. Also run STAGES=6 MODULUS=16 wrap from 0xFFFFFF.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared types and helpers for the cascaded mod-N up/down counter.
// Provides default geometry, the clr/load/step priority encoder and a digit-slice macro.
`ifndef CASCADE_COUNTER_PKG_SV
`define CASCADE_COUNTER_PKG_SV

`define CC_DIGIT(vec, i, w) vec[(i)*(w) +: (w)]

package cascade_counter_pkg;

  localparam int STAGES_DEF  = 6;
  localparam int DIGIT_W_DEF = 4;
  localparam int MODULUS_DEF = 10;
  localparam int CNT_W       = STAGES_DEF * DIGIT_W_DEF;
  localparam int DIGIT_MAX   = MODULUS_DEF - 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  // clr beats load beats counting, whatever the other controls say
  function automatic op_e cc_op(input logic clr, input logic load, input logic step);
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (step) return OP_STEP;
    else           return OP_HOLD;
  endfunction

endpackage

`endif

// File: rtl/cascade_counter_if.sv
// Control/status bundle between a lab top level and cascade_counter.
interface cascade_counter_if
  import cascade_counter_pkg::*;
#(
  parameter int STAGES  = STAGES_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
);

  localparam int W = STAGES * DIGIT_W;

  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap_o;

  modport master (
    output clr, load, load_val, en, up,
    input  count, tc, wrap_o
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, tc, wrap_o
  );

endinterface

// File: rtl/cascade_counter_digit.sv
// One mod-MODULUS up/down digit of the cascade; steps when its carry/borrow-in is set.
// hold_i freezes stepping without disturbing tc_o, which lets the top saturate loop-free.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ci,
  input  logic               hold_i,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               tc_o
);

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(MODULUS - 1);
  localparam logic [DIGIT_W:0]   MODV = (DIGIT_W + 1)'(MODULUS);

  logic [DIGIT_W-1:0] q_q, q_d;
  logic               atTerm;

  assign atTerm = up ? (q_q == DMAX) : (q_q == '0);
  assign tc_o   = ci & atTerm;

  // Out-of-range load values collapse to zero so the digit never leaves 0..MODULUS-1
  always_comb begin
    q_d = q_q;
    case (cc_op(clr, load, ci & ~hold_i))
      OP_CLR:  q_d = '0;
      OP_LOAD: q_d = ({1'b0, load_val} >= MODV) ? '0 : load_val;
      OP_STEP: begin
        if (up) q_d = (q_q == DMAX) ? '0 : q_q + DIGIT_W'(1);
        else    q_d = (q_q == '0) ? DMAX : q_q - DIGIT_W'(1);
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cascade_counter.sv
// STAGES-digit cascaded mod-MODULUS up/down counter with load, clear and full-wrap pulse.
// Define CASCADE_COUNTER_SATURATE_EN to make the counter stick at its end values instead of wrapping.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int STAGES  = 6,
  parameter int DIGIT_W = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  cascade_counter_if.slave bus
);

  localparam int W = STAGES * DIGIT_W;

  logic [STAGES-1:0] ci;
  logic [STAGES-1:0] tcVec;
  logic [W-1:0]      countW;
  logic              hold;
  logic              wrap_q, wrap_d;

  // Each digit's terminal flag already includes its own carry-in, so chaining them
  // gives "all lower digits at terminal" for free.
  for (genvar i = 0; i < STAGES; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign ci[i] = bus.en;
    end else begin : g_rest
      assign ci[i] = tcVec[i-1];
    end

    counter_digit #(
      .DIGIT_W (DIGIT_W),
      .MODULUS (MODULUS)
    ) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .ci       (ci[i]),
      .hold_i   (hold),
      .clr      (bus.clr),
      .load     (bus.load),
      .load_val (`CC_DIGIT(bus.load_val, i, DIGIT_W)),
      .up       (bus.up),
      .q        (`CC_DIGIT(countW, i, DIGIT_W)),
      .tc_o     (tcVec[i])
    );
  end

  assign bus.tc = &tcVec;

`ifdef CASCADE_COUNTER_SATURATE_EN
  assign hold   = bus.tc;
  assign wrap_d = 1'b0;
`else
  assign hold   = 1'b0;
  assign wrap_d = (cc_op(bus.clr, bus.load, bus.tc) == OP_STEP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= wrap_d;
  end

  assign bus.count  = countW;
  assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter: a 2-digit BCD instance and a 6-digit hex instance,
// checked every cycle against a whole-number model plus hand-computed literals.
module tb_cascade_counter;

`ifdef CASCADE_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  cascade_counter_if #(.STAGES(2), .DIGIT_W(4)) busA ();
  cascade_counter_if #(.STAGES(6), .DIGIT_W(4)) busB ();

  cascade_counter #(.STAGES(2), .DIGIT_W(4), .MODULUS(10)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  cascade_counter #(.STAGES(6), .DIGIT_W(4), .MODULUS(16)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  // Model: the counter is a single integer in 0..MODULUS**STAGES-1
  function automatic longint maxVal(input int st, input int md);
    longint r = 1;
    for (int i = 0; i < st; i++) r = r * md;
    return r - 1;
  endfunction

  function automatic longint pack2val(input logic [23:0] v, input int st, input int md);
    longint r = 0;
    int     d;
    for (int i = st - 1; i >= 0; i--) begin
      d = int'(v[i*4 +: 4]);
      if (d >= md) d = 0;
      r = r * md + d;
    end
    return r;
  endfunction

  function automatic logic [23:0] val2pack(input longint v, input int st, input int md);
    logic [23:0] r = '0;
    longint      t = v;
    for (int i = 0; i < st; i++) begin
      r[i*4 +: 4] = 4'(t % md);
      t = t / md;
    end
    return r;
  endfunction

  function automatic logic tcModel(input longint m, input logic en, input logic up,
                                   input int st, input int md);
    return en & (up ? (m == maxVal(st, md)) : (m == 0));
  endfunction

  task automatic modelStep(inout longint m, inout logic w, input logic clr, input logic load,
                           input logic [23:0] lv, input logic en, input logic up,
                           input int st, input int md);
    longint mx = maxVal(st, md);
    w = 1'b0;
    if (clr) m = 0;
    else if (load) m = pack2val(lv, st, md);
    else if (en) begin
      if (tcModel(m, en, up, st, md)) begin
        if (!SAT) begin
          m = up ? 0 : mx;
          w = 1'b1;
        end
      end else begin
        m = up ? m + 1 : m - 1;
      end
    end
  endtask

  longint mA = 0, mB = 0;
  logic   wA = 1'b0, wB = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mA = 0; mB = 0; wA = 1'b0; wB = 1'b0;
    end else begin
      modelStep(mA, wA, busA.clr, busA.load, {16'b0, busA.load_val}, busA.en, busA.up, 2, 10);
      modelStep(mB, wB, busB.clr, busB.load, busB.load_val, busB.en, busB.up, 6, 16);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("modelCountA", 32'(busA.count), 32'(val2pack(mA, 2, 10)));
    checkOutput("modelTcA", 32'(busA.tc), 32'(tcModel(mA, busA.en, busA.up, 2, 10)));
    checkOutput("modelWrapA", 32'(busA.wrap_o), 32'(wA));
    checkOutput("modelCountB", 32'(busB.count), 32'(val2pack(mB, 6, 16)));
    checkOutput("modelTcB", 32'(busB.tc), 32'(tcModel(mB, busB.en, busB.up, 6, 16)));
    checkOutput("modelWrapB", 32'(busB.wrap_o), 32'(wB));
  end

  // Drive one instance's controls, then let exactly one rising edge sample them
  task automatic applyStimulus(input bit selB, input logic clr, input logic load,
                               input logic [23:0] val, input logic en, input logic up);
    if (selB) begin
      busB.clr = clr; busB.load = load; busB.load_val = val; busB.en = en; busB.up = up;
    end else begin
      busA.clr = clr; busA.load = load; busA.load_val = val[7:0]; busA.en = en; busA.up = up;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.clr = 0; busA.load = 0; busA.load_val = '0; busA.en = 0; busA.up = 1;
    busB.clr = 0; busB.load = 0; busB.load_val = '0; busB.en = 0; busB.up = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetCountA", 32'(busA.count), 32'h00);
    checkOutput("resetWrapA", 32'(busA.wrap_o), 32'h0);
    checkOutput("resetCountB", 32'(busB.count), 32'h000000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] up through 99");
    applyStimulus(0, 0, 1, 24'h98, 0, 1);
    checkOutput("load98", 32'(busA.count), 32'h98);
    applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("up99", 32'(busA.count), 32'h99);
    checkOutput("up99Tc", 32'(busA.tc), 32'h1);
    applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("upWrap", 32'(busA.count), SAT ? 32'h99 : 32'h00);
    checkOutput("upWrapPulse", 32'(busA.wrap_o), SAT ? 32'h0 : 32'h1);
    applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("upAfterWrap", 32'(busA.count), SAT ? 32'h99 : 32'h01);
    checkOutput("wrapOneCycle", 32'(busA.wrap_o), 32'h0);

    $display("[TB] down through 00");
    applyStimulus(0, 0, 1, 24'h01, 0, 0);
    applyStimulus(0, 0, 0, 24'h0, 1, 0);
    checkOutput("down00", 32'(busA.count), 32'h00);
    checkOutput("down00Tc", 32'(busA.tc), 32'h1);
    applyStimulus(0, 0, 0, 24'h0, 1, 0);
    checkOutput("downWrap", 32'(busA.count), SAT ? 32'h00 : 32'h99);
    checkOutput("downWrapPulse", 32'(busA.wrap_o), SAT ? 32'h0 : 32'h1);
    applyStimulus(0, 0, 1, 24'h10, 0, 0);
    applyStimulus(0, 0, 0, 24'h0, 1, 0);
    checkOutput("borrow", 32'(busA.count), 32'h09);

    $display("[TB] illegal load and priority");
    applyStimulus(0, 0, 1, 24'h5C, 0, 1);
    checkOutput("loadIllegal", 32'(busA.count), 32'h50);
    applyStimulus(0, 1, 1, 24'h77, 1, 1);
    checkOutput("clrPriority", 32'(busA.count), 32'h00);
    applyStimulus(0, 0, 1, 24'h42, 1, 0);
    checkOutput("loadOverEn", 32'(busA.count), 32'h42);
    applyStimulus(0, 1, 0, 24'h0, 0, 1);

    $display("[TB] enable toggling and direction flip");
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 24'h0, (k % 2 == 0), 1);
    checkOutput("toggle20", 32'(busA.count), 32'h10);
    checkOutput("toggleNoWrap", 32'(busA.wrap_o), 32'h0);
    applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("flipUp", 32'(busA.count), 32'h11);
    applyStimulus(0, 0, 0, 24'h0, 1, 0);
    checkOutput("flipDown", 32'(busA.count), 32'h10);

    $display("[TB] runs past the ends");
    applyStimulus(0, 0, 1, 24'h99, 0, 1);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("up5From99", 32'(busA.count), SAT ? 32'h99 : 32'h04);
    checkOutput("up5Wrap", 32'(busA.wrap_o), 32'h0);
    applyStimulus(0, 0, 1, 24'h00, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 24'h0, 1, 0);
    checkOutput("down5From00", 32'(busA.count), SAT ? 32'h00 : 32'h95);
    applyStimulus(0, 0, 0, 24'h0, 0, 1);

    $display("[TB] six hex digits");
    applyStimulus(1, 0, 1, 24'hFFFFFF, 0, 1);
    checkOutput("loadFFFFFF", 32'(busB.count), 32'hFFFFFF);
    applyStimulus(1, 0, 0, 24'h0, 1, 1);
    checkOutput("hexUpWrap", 32'(busB.count), SAT ? 32'hFFFFFF : 32'h000000);
    checkOutput("hexUpPulse", 32'(busB.wrap_o), SAT ? 32'h0 : 32'h1);
    applyStimulus(1, 0, 1, 24'h00F0FF, 0, 1);
    applyStimulus(1, 0, 0, 24'h0, 1, 1);
    checkOutput("hexRipple", 32'(busB.count), 32'h00F100);
    applyStimulus(1, 1, 0, 24'h0, 0, 0);
    applyStimulus(1, 0, 0, 24'h0, 1, 0);
    checkOutput("hexDownWrap", 32'(busB.count), SAT ? 32'h000000 : 32'hFFFFFF);
    applyStimulus(1, 0, 0, 24'h0, 0, 1);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(0, 0, 1, 24'h37, 0, 1);
    checkOutput("load37", 32'(busA.count), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetCount", 32'(busA.count), 32'h00);
    checkOutput("asyncResetWrap", 32'(busA.wrap_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 24'h0, 1, 1);
    checkOutput("countAfterReset", 32'(busA.count), 32'h01);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
